// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: latches operands, starts the selected unit, waits
// for its completion (bounded by TIMEOUT) and loads the architectural HI/LO pair.
module muldiv_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MD_REQ,
  input  logic [1:0]  MD_OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] OP_A,
  output logic [31:0] OP_B,
  output logic        DIV_START,
  output logic        MULT_START,
  input  logic        DIV_END,
  input  logic        MULT_END,
  input  logic        DIV_0,
  input  logic [31:0] DIV_HI,
  input  logic [31:0] DIV_LO,
  input  logic [31:0] MULT_HI,
  input  logic [31:0] MULT_LO,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        MD_BUSY,
  output logic        MD_DONE,
  output logic        DIV_ZERO_EXC,
  output logic        MD_TIMEOUT
);

  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, ERR} state_t;

  localparam logic [6:0] TO_LIM = 7'(TIMEOUT);

  state_t     state;
  logic       is_div;
  logic [5:0] cnt;
  logic [6:0] cnt_inc;
  logic [5:0] cnt_sat;
  logic       unit_end;

  assign cnt_inc  = {1'b0, cnt} + 7'd1;
  assign cnt_sat  = cnt_inc[6] ? 6'h3f : cnt_inc[5:0];
  assign unit_end = is_div ? DIV_END : MULT_END;
  assign MD_BUSY  = (state != IDLE);

  // DIV_0 only reflects the latched divisor once in START, so the start
  // strobes are decoded from the state rather than registered a cycle early.
  assign DIV_START  = (state == START) &&  is_div && !DIV_0;
  assign MULT_START = (state == START) && !is_div;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      is_div       <= 1'b0;
      cnt          <= '0;
      OP_A         <= '0;
      OP_B         <= '0;
      HI           <= '0;
      LO           <= '0;
      MD_DONE      <= 1'b0;
      DIV_ZERO_EXC <= 1'b0;
      MD_TIMEOUT   <= 1'b0;
    end else begin
      MD_DONE      <= 1'b0;
      DIV_ZERO_EXC <= 1'b0;
      MD_TIMEOUT   <= 1'b0;
      case (state)
        IDLE: begin
          if (MD_REQ && (MD_OP == 2'b01 || MD_OP == 2'b10)) begin
            OP_A   <= A;
            OP_B   <= B;
            is_div <= (MD_OP == 2'b10);
            state  <= START;
          end
        end
        START: begin
          cnt <= '0;
          if (is_div && DIV_0) begin
            DIV_ZERO_EXC <= 1'b1;
            state        <= ERR;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt_sat;
          // completion takes priority over a timeout hit in the same cycle
          if (unit_end) begin
            HI      <= is_div ? DIV_HI : MULT_HI;
            LO      <= is_div ? DIV_LO : MULT_LO;
            MD_DONE <= 1'b1;
            state   <= DONE;
          end else if ({1'b0, cnt_sat} >= TO_LIM) begin
            MD_TIMEOUT <= 1'b1;
            state      <= ERR;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl: behavioural unit models plus a
// per-operation outcome model (busy length, pulses, HI/LO).
module tb_muldiv_ctrl;
  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        MD_REQ = 1'b0;
  logic [1:0]  MD_OP = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic [31:0] OP_A, OP_B, HI, LO;
  logic        DIV_START, MULT_START, MD_BUSY, MD_DONE, DIV_ZERO_EXC, MD_TIMEOUT;
  logic        DIV_END = 1'b0, MULT_END = 1'b0, DIV_0;
  logic [31:0] DIV_HI = '0, DIV_LO = '0, MULT_HI = '0, MULT_LO = '0;

  int n_tests = 0, n_fail = 0;
  int div_lat = 1, mult_lat = 1, d_rem = 0, m_rem = 0;
  logic [31:0] da = '0, db = '0, ma = '0, mb = '0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  muldiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .MD_REQ(MD_REQ), .MD_OP(MD_OP), .A(A), .B(B),
    .OP_A(OP_A), .OP_B(OP_B), .DIV_START(DIV_START), .MULT_START(MULT_START),
    .DIV_END(DIV_END), .MULT_END(MULT_END), .DIV_0(DIV_0),
    .DIV_HI(DIV_HI), .DIV_LO(DIV_LO), .MULT_HI(MULT_HI), .MULT_LO(MULT_LO),
    .HI(HI), .LO(LO), .MD_BUSY(MD_BUSY), .MD_DONE(MD_DONE),
    .DIV_ZERO_EXC(DIV_ZERO_EXC), .MD_TIMEOUT(MD_TIMEOUT)
  );

  always #5 clock = ~clock;

  assign DIV_0 = (OP_B == 32'd0);

  function automatic logic [31:0] qdiv(input logic [31:0] a, b);
    return (b == 0) ? 32'd0 : a / b;
  endfunction
  function automatic logic [31:0] qrem(input logic [31:0] a, b);
    return (b == 0) ? 32'd0 : a % b;
  endfunction

  // Unit models: END rises in the lat-th cycle after the start cycle and stays
  // high until the next start; results are junk until END. Not reset-sensitive,
  // so an operation in flight at reset still delivers a late END.
  always @(posedge clock) begin
    if (DIV_START) begin
      da <= OP_A; db <= OP_B; d_rem <= div_lat - 1;
      DIV_END <= (div_lat == 1);
      DIV_HI  <= (div_lat == 1) ? qrem(OP_A, OP_B) : $urandom;
      DIV_LO  <= (div_lat == 1) ? qdiv(OP_A, OP_B) : $urandom;
    end else if (d_rem > 0) begin
      d_rem <= d_rem - 1;
      if (d_rem == 1) begin
        DIV_END <= 1'b1; DIV_HI <= qrem(da, db); DIV_LO <= qdiv(da, db);
      end
    end
    if (MULT_START) begin
      ma <= OP_A; mb <= OP_B; m_rem <= mult_lat - 1;
      MULT_END <= (mult_lat == 1);
      {MULT_HI, MULT_LO} <= (mult_lat == 1) ? 64'(OP_A) * 64'(OP_B) : {$urandom, $urandom};
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        MULT_END <= 1'b1; {MULT_HI, MULT_LO} <= 64'(ma) * 64'(mb);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request (called at a negedge) and check the whole operation.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit inject);
    int  busy_n = 0, ds_n = 0, ms_n = 0, done_n = 0, zx_n = 0, to_n = 0;
    int  pulse_at = -1, st_at = -1, cyc = 0;
    int  e_busy = 0, e_done = 0, e_zx = 0, e_to = 0, e_ds = 0, e_ms = 0;
    bit  valid = (op == 2'b01) || (op == 2'b10);
    bit  isdiv = (op == 2'b10);
    logic [31:0] oa = '0, ob = '0;

    if (valid) begin
      e_ds = (isdiv && b != 0) ? 1 : 0;
      e_ms = isdiv ? 0 : 1;
      if (isdiv && b == 0) begin
        e_busy = 2; e_zx = 1;
      end else if (lat <= TIMEOUT) begin
        e_busy = lat + 2; e_done = 1;
        if (isdiv) begin exp_hi = a % b; exp_lo = a / b; end
        else {exp_hi, exp_lo} = 64'(a) * 64'(b);
      end else begin
        e_busy = TIMEOUT + 2; e_to = 1;
      end
    end

    div_lat = lat; mult_lat = lat;
    MD_REQ = 1'b1; MD_OP = op; A = a; B = b;
    @(posedge clock); @(negedge clock);
    MD_REQ = 1'b0; A = $urandom; B = $urandom;
    while (MD_BUSY && cyc < 100) begin
      if (cyc == 0) begin oa = OP_A; ob = OP_B; end
      busy_n++;
      if (DIV_START)  begin ds_n++; st_at = cyc; end
      if (MULT_START) begin ms_n++; st_at = cyc; end
      if (MD_DONE)      begin done_n++; pulse_at = cyc; end
      if (DIV_ZERO_EXC) begin zx_n++;   pulse_at = cyc; end
      if (MD_TIMEOUT)   begin to_n++;   pulse_at = cyc; end
      // a request mid-operation must be dropped
      MD_REQ = inject && (cyc == 1);
      MD_OP  = 2'b01;
      @(negedge clock); cyc++;
    end
    MD_REQ = 1'b0;

    chk("busy_cycles", busy_n, e_busy);
    chk("div_start_n", ds_n, e_ds);
    chk("mult_start_n", ms_n, e_ms);
    chk("done_n", done_n, e_done);
    chk("zero_exc_n", zx_n, e_zx);
    chk("timeout_n", to_n, e_to);
    chk("hi", HI, exp_hi);
    chk("lo", LO, exp_lo);
    if (valid) begin
      chk("op_a", oa, a);
      chk("op_b", ob, b);
      chk("pulse_cycle", pulse_at, e_busy - 1);
      if (e_ds + e_ms > 0) chk("start_cycle", st_at, 0);
    end
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] b;
    int          lat, busy_n, done_n;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", MD_BUSY, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_opa", OP_A, 0);
    chk("rst_opb", OP_B, 0);
    chk("rst_pulses", {DIV_START, MULT_START, MD_DONE, DIV_ZERO_EXC, MD_TIMEOUT}, 0);
    reset = 1'b0;

    run_op(2'b10, 32'd100, 32'd7, 33, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 4, 1'b0);
    run_op(2'b10, 32'd55, 32'd0, 5, 1'b0);
    run_op(2'b10, 32'd9, 32'd3, 200, 1'b0);
    run_op(2'b10, 32'd1000, 32'd10, TIMEOUT, 1'b0);
    run_op(2'b01, 32'd6, 32'd7, 3, 1'b1);
    run_op(2'b10, 32'd77, 32'd5, 2, 1'b1);
    run_op(2'b00, 32'd1, 32'd1, 3, 1'b0);
    run_op(2'b11, 32'd1, 32'd1, 3, 1'b0);
    run_op(2'b01, 32'd3, 32'd3, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      b   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      lat = ($urandom_range(0, 5) == 0) ? $urandom_range(38, 60) : $urandom_range(1, 12);
      run_op(op, $urandom, b, lat, 1'($urandom_range(0, 1)));
    end

    // reset in WAIT, then the divider's late END must go unnoticed
    div_lat = 20;
    MD_REQ = 1'b1; MD_OP = 2'b10; A = 32'd500; B = 32'd3;
    @(posedge clock); @(negedge clock);
    MD_REQ = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; exp_hi = '0; exp_lo = '0;
    chk("mid_rst_busy", MD_BUSY, 0);
    chk("mid_rst_hi", HI, 0);
    chk("mid_rst_opa", OP_A, 0);
    chk("mid_rst_pulses", {DIV_START, MULT_START, MD_DONE, DIV_ZERO_EXC, MD_TIMEOUT}, 0);
    busy_n = 0; done_n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (MD_BUSY) busy_n++;
      if (MD_DONE || MD_TIMEOUT || DIV_ZERO_EXC) done_n++;
    end
    chk("late_end_busy", busy_n, 0);
    chk("late_end_pulses", done_n, 0);
    chk("late_end_hi", HI, 0);
    run_op(2'b10, 32'd100, 32'd7, 6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL provide parameter TIMEOUT, default 40, meaning the maximum number of WAIT-state cycles allowed before an operation is aborted.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high; the ports SHALL be named clock and reset.
REQ-003 Port: clock  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  synchronous active-high reset.
REQ-005 Port: MD_REQ  in  1  operation request, sampled in IDLE only.
REQ-006 Port: MD_OP  in  2  operation select: 01 MULT, 10 DIV; 00 and 11 are no-op.
REQ-007 Port: A, B  in  32 each  operands, sampled together with MD_REQ.
REQ-008 Port: OP_A, OP_B  out  32 each  latched operands driven to both units.
REQ-009 Port: DIV_START, MULT_START  out  1 each  unit start pulses.
REQ-010 Port: DIV_END, MULT_END  in  1 each  unit completion flags (level; may stay high until the next start).
REQ-011 Port: DIV_0  in  1  divider zero-divisor flag, combinational on OP_B.
REQ-012 Port: DIV_HI, DIV_LO, MULT_HI, MULT_LO  in  32 each  unit results.
REQ-013 Port: HI, LO  out  32 each  architectural HI/LO registers.
REQ-014 Port: MD_BUSY  out  1  CPU stall.
REQ-015 Port: MD_DONE, DIV_ZERO_EXC, MD_TIMEOUT  out  1 each  one-cycle status pulses.

Function
REQ-016 The FSM SHALL have the states IDLE, START, WAIT, DONE and ERR.
REQ-017 MD_BUSY SHALL be combinational, equal to (state != IDLE).
REQ-018 IDLE: on MD_REQ=1 with MD_OP of 01 or 10, the block SHALL latch A/B into OP_A/OP_B and MD_OP internally, then go to START.
REQ-019 IDLE: MD_REQ with MD_OP of 00 or 11 SHALL be ignored, with no state change.
REQ-020 START, DIV op with DIV_0=1: the block SHALL go to ERR, SHALL not assert DIV_START, and SHALL leave HI/LO unchanged.
REQ-021 START, otherwise: the block SHALL assert the selected *_START for exactly this one cycle, clear the timeout counter, and go to WAIT.
REQ-022 The block SHALL ignore *_END while in START, so a stale END from the previous operation has no effect.
REQ-023 WAIT: the block SHALL increment the 6-bit saturating counter each cycle.
REQ-024 WAIT: when the selected *_END=1, the block SHALL load HI/LO from that unit's outputs on the same edge and go to DONE.
REQ-025 WAIT: when the counter reaches TIMEOUT with END still 0, the block SHALL go to ERR with HI/LO unchanged.
REQ-026 WAIT: END and the timeout reached in the same cycle SHALL resolve as completion; END wins.
REQ-027 DONE: the block SHALL assert MD_DONE for one cycle, then return to IDLE.
REQ-028 ERR: the block SHALL pulse DIV_ZERO_EXC (divide-by-zero cause) or MD_TIMEOUT (timeout cause) for one cycle, then return to IDLE.
REQ-029 The unselected unit's END and results SHALL be ignored throughout.
REQ-030 MD_REQ asserted in any state other than IDLE SHALL be dropped; requests SHALL not be queued.
REQ-031 Latency SHALL be request edge -> START (1 cycle) -> WAIT (N cycles, where N = unit latency) -> DONE; MD_BUSY SHALL be high for N+2 cycles.
REQ-032 A request SHALL be accepted in the cycle immediately after DONE.

Reset
REQ-033 On reset, state, counter, OP_A, OP_B, HI and LO SHALL go to IDLE/0.
REQ-034 On reset, DIV_START, MULT_START, MD_DONE, DIV_ZERO_EXC and MD_TIMEOUT SHALL be 0.
REQ-035 Reset mid-operation SHALL abort the operation with no further pulses; a late END arriving after the reset SHALL be ignored.

Verification
REQ-036 DIV, A=100, B=7, divider model returning END 33 cycles after start -> a single DIV_START pulse; HI=2, LO=14; MD_DONE one cycle; MD_BUSY for 35 cycles.
REQ-037 MULT, A=0xFFFFFFFF, B=2, model returning MULT_HI=1 and MULT_LO=0xFFFFFFFE -> HI/LO loaded with those values; DIV_START never asserted.
REQ-038 DIV with B=0 -> no DIV_START; DIV_ZERO_EXC pulses 2 cycles after the request; HI/LO keep prior values.
REQ-039 DIV with END held low and TIMEOUT=40 -> MD_TIMEOUT pulses after 40 WAIT cycles; back in IDLE on the next cycle.
REQ-040 Second MD_REQ issued mid-WAIT, then stale DIV_END still high at the next request -> the second request is dropped; the next operation waits for a fresh END.
REQ-041 Reset asserted in WAIT -> outputs 0 next cycle; a later END produces no MD_DONE.
